// File: rtl/pcie_dma_burst_master.sv
// Avalon-MM burst master from the DMA engine to the PCIe txs port.
// Issues multi-beat read/write bursts; a progress watchdog aborts hung transfers.
module pcie_dma_burst_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int BURST_WIDTH    = 10,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dma_request,
    input  logic                    dma_wrdn,
    input  logic [ADDR_WIDTH-1:0]   dma_addr,
    input  logic [BURST_WIDTH-1:0]  dma_xfer_cnt,
    input  logic [DATA_WIDTH-1:0]   dma_data,
    input  logic [DATA_WIDTH/8-1:0] dma_cbe,
    output logic                    dma_src_en,
    output logic                    dma_data_vld,
    output logic [DATA_WIDTH-1:0]   dma_rd_data,
    output logic                    dma_complete,
    output logic                    dma_error,
    output logic                    dma_lat_timeout,
    output logic                    busy,
    output logic                    txs_chip_select,
    output logic                    txs_read,
    output logic                    txs_write,
    output logic [ADDR_WIDTH-1:0]   txs_address,
    output logic [BURST_WIDTH-1:0]  txs_burst_count,
    output logic [DATA_WIDTH-1:0]   txs_writedata,
    output logic [DATA_WIDTH/8-1:0] txs_byteenable,
    input  logic                    txs_read_valid,
    input  logic [DATA_WIDTH-1:0]   txs_readdata,
    input  logic                    txs_wait_request
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BURST_WIDTH-1:0] MAX_BURST = BURST_WIDTH'(2 ** (BURST_WIDTH - 1));
    localparam logic [WD_W-1:0]        WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR, DONE} state_t;

    state_t                 r_state;
    logic [BURST_WIDTH-1:0] r_beats_left;
    logic [WD_W-1:0]        r_wdog;

    logic w_cnt_ok, w_active, w_rd_accept, w_rd_beat, w_rd_done;
    logic w_wr_accept, w_more, w_progress, w_timeout;

    assign w_cnt_ok    = (dma_xfer_cnt != '0) && (dma_xfer_cnt <= MAX_BURST);
    assign w_active    = (r_state == RD_CMD) || (r_state == RD_DATA) || (r_state == WR);
    assign w_rd_accept = (r_state == RD_CMD) && !txs_wait_request;
    // A beat returned in the same cycle the command is accepted still counts.
    assign w_rd_beat   = ((r_state == RD_CMD) || (r_state == RD_DATA)) && txs_read_valid
                         && (r_beats_left != '0);
    assign w_rd_done   = (r_state == RD_DATA) && (r_beats_left == '0);
    assign w_wr_accept = (r_state == WR) && txs_write && !txs_wait_request;
    assign w_more      = r_beats_left > BURST_WIDTH'(1);
    assign w_progress  = w_rd_accept || w_rd_beat || w_wr_accept;
    assign w_timeout   = w_active && !w_progress && !w_rd_done && (r_wdog == WD_LAST);

    // Producer handshake: first beat on the launch edge, then one per accepted non-final beat.
    assign dma_src_en = ((r_state == IDLE) && dma_request && dma_wrdn && w_cnt_ok)
                        || (w_wr_accept && w_more);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_beats_left    <= '0;
            r_wdog          <= '0;
            busy            <= 1'b0;
            dma_data_vld    <= 1'b0;
            dma_rd_data     <= '0;
            dma_complete    <= 1'b0;
            dma_error       <= 1'b0;
            dma_lat_timeout <= 1'b0;
            txs_chip_select <= 1'b0;
            txs_read        <= 1'b0;
            txs_write       <= 1'b0;
            txs_address     <= '0;
            txs_burst_count <= '0;
            txs_writedata   <= '0;
            txs_byteenable  <= '0;
        end else begin
            dma_data_vld    <= w_rd_beat;
            dma_complete    <= 1'b0;
            dma_error       <= 1'b0;
            dma_lat_timeout <= 1'b0;
            if (w_rd_beat)
                dma_rd_data <= txs_readdata;

            if (w_timeout) begin
                txs_chip_select <= 1'b0;
                txs_read        <= 1'b0;
                txs_write       <= 1'b0;
                dma_lat_timeout <= 1'b1;
                dma_complete    <= 1'b1;
                dma_error       <= 1'b1;
                r_wdog          <= '0;
                r_state         <= DONE;
            end else begin
                if (w_active)
                    r_wdog <= w_progress ? '0 : r_wdog + 1'b1;
                else
                    r_wdog <= '0;

                case (r_state)
                    IDLE: begin
                        if (dma_request) begin
                            busy         <= 1'b1;
                            r_beats_left <= dma_xfer_cnt;
                            if (!w_cnt_ok) begin
                                dma_complete <= 1'b1;
                                dma_error    <= 1'b1;
                                r_state      <= DONE;
                            end else begin
                                txs_chip_select <= 1'b1;
                                txs_address     <= dma_addr;
                                txs_burst_count <= dma_xfer_cnt;
                                if (dma_wrdn) begin
                                    txs_write      <= 1'b1;
                                    txs_writedata  <= dma_data;
                                    txs_byteenable <= ~dma_cbe;
                                    r_state        <= WR;
                                end else begin
                                    txs_read       <= 1'b1;
                                    txs_byteenable <= {BE_WIDTH{1'b1}};
                                    r_state        <= RD_CMD;
                                end
                            end
                        end
                    end
                    RD_CMD: begin
                        if (w_rd_beat)
                            r_beats_left <= r_beats_left - 1'b1;
                        if (w_rd_accept) begin
                            txs_read <= 1'b0;
                            r_state  <= RD_DATA;
                        end
                    end
                    RD_DATA: begin
                        // Completion waits one cycle so it trails the last dma_data_vld.
                        if (w_rd_done) begin
                            txs_chip_select <= 1'b0;
                            dma_complete    <= 1'b1;
                            r_state         <= DONE;
                        end else if (w_rd_beat) begin
                            r_beats_left <= r_beats_left - 1'b1;
                        end
                    end
                    WR: begin
                        if (w_wr_accept) begin
                            if (w_more) begin
                                txs_writedata  <= dma_data;
                                txs_byteenable <= ~dma_cbe;
                                r_beats_left   <= r_beats_left - 1'b1;
                            end else begin
                                txs_write       <= 1'b0;
                                txs_chip_select <= 1'b0;
                                dma_complete    <= 1'b1;
                                r_state         <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/pcie_dma_burst_master.md
# pcie_dma_burst_master

Parametrised Avalon-MM burst master between the NetFPGA DMA engine and the Altera PCIe core's TX slave (txs) port, used for host-memory DMA traffic. Unlike the single-beat-read bridge it supersedes, it issues multi-beat read and write bursts of configurable data width, which removes the per-word round trip on DMA reads. It also adds a progress watchdog that aborts hung transfers and reports them to the DMA engine. It sits between dma_engine_pci_xfer and the PCIe hard-IP wrapper; the target (rxm) path is not part of this block.

## Interface
Parameters:
- DATA_WIDTH, 32: data bus width in bits (32 or 64); BE_WIDTH = DATA_WIDTH/8.
- ADDR_WIDTH, 32: byte address width.
- BURST_WIDTH, 10: txs_burst_count width; MAX_BURST = 2^(BURST_WIDTH-1).
- TIMEOUT_CYCLES, 4096: cycles without progress before abort (≥ 2).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- dma_request  in  1  start a transfer; sampled in IDLE only.
- dma_wrdn  in  1  1 = write to host, 0 = read from host; sampled with dma_request.
- dma_addr  in  ADDR_WIDTH  start byte address; sampled with dma_request.
- dma_xfer_cnt  in  BURST_WIDTH  beat count; sampled with dma_request.
- dma_data  in  DATA_WIDTH  current write beat.
- dma_cbe  in  BE_WIDTH  active-low byte enables for the current beat.
- dma_src_en  out  1  combinational; the bridge consumes dma_data/dma_cbe this cycle, and the producer advances on this edge.
- dma_data_vld  out  1  read beat valid on dma_rd_data.
- dma_rd_data  out  DATA_WIDTH  read data to the DMA engine.
- dma_complete  out  1  one-cycle pulse at the end of a transfer.
- dma_error  out  1  qualifies dma_complete: rejected or timed-out transfer.
- dma_lat_timeout  out  1  one-cycle pulse on watchdog abort.
- busy  out  1  high in any state other than IDLE.
- txs_chip_select, txs_read, txs_write  out  1  Avalon command.
- txs_address  out  ADDR_WIDTH; txs_burst_count  out  BURST_WIDTH; txs_writedata  out  DATA_WIDTH; txs_byteenable  out  BE_WIDTH.
- txs_read_valid  in  1; txs_readdata  in  DATA_WIDTH; txs_wait_request  in  1.

## Operation
- States: IDLE, RD_CMD, RD_DATA, WR, DONE.
- IDLE, on dma_request:
  - Latch wrdn, addr and cnt.
  - If cnt == 0 or cnt > MAX_BURST: go to DONE with error=1 and issue no bus cycle.
  - Otherwise go to RD_CMD (read) or WR (write), with beats_left = cnt.
- RD_CMD:
  - txs_read, txs_chip_select, txs_address and txs_burst_count = cnt are registered, asserted from the first cycle.
  - txs_byteenable is all ones.
  - Held until a cycle with !txs_wait_request, then deassert read and go to RD_DATA.
- RD_DATA:
  - Each txs_read_valid: dma_rd_data <= txs_readdata, dma_data_vld=1 the next cycle, beats_left decrements.
  - beats_left reaching 0 -> DONE, error=0.
  - txs_read_valid in the same cycle the command is accepted (RD_CMD) is counted.
- WR:
  - On entry, txs_write=1 with txs_burst_count=cnt on the first beat.
  - The first beat is loaded from dma_data, with dma_src_en=1 in the IDLE→WR cycle.
  - Each cycle with txs_write && !txs_wait_request is an accepted beat:
    - If beats_left > 1: load the next dma_data/~dma_cbe, pulse dma_src_en, decrement.
    - Else: drop write and chip_select, then go to DONE.
  - dma_src_en is never asserted while txs_wait_request holds the current beat.
  - txs_byteenable = ~dma_cbe, captured per beat.
- DONE: pulse dma_complete (and dma_error if the error flag is set), then go to IDLE.
- Watchdog:
  - The counter clears on state entry, on command accept and on every accepted or returned beat.
  - Reaching TIMEOUT_CYCLES in RD_CMD, RD_DATA or WR:
    - Deassert all txs command outputs.
    - Pulse dma_lat_timeout.
    - Go to DONE with error=1.
- txs_read_valid in IDLE is discarded and never forwarded.
- dma_request while busy is ignored.

## Timing
- All outputs except dma_src_en are registered.
- Reset values: txs_* = 0 (chip_select, read, write, address, burst_count, writedata, byteenable); dma_data_vld, dma_rd_data, dma_complete, dma_error, dma_lat_timeout, busy = 0; state IDLE; counters 0.
- Read: command visible 1 cycle after dma_request; dma_data_vld lags txs_read_valid by 1 cycle; dma_complete follows the last dma_data_vld by 1 cycle.
- Write: first beat visible 1 cycle after dma_request; with no waitrequest, one beat per cycle.
- dma_complete: 1 cycle after the last accepted beat.
- Minimum IDLE dwell between transfers: 1 cycle (DONE→IDLE, then sample).
- Reset mid-transfer: all outputs go to reset values immediately (asynchronous), with no dma_complete.

## Test plan
- Write, cnt=4, DATA_WIDTH=32, no waitrequest:
  - 4 consecutive beats with burst_count=4 on the first.
  - 4 dma_src_en pulses.
  - dma_complete 1 cycle after the 4th beat; dma_error=0.
- Write, cnt=3, waitrequest high on cycles 2–4:
  - Beat 2 held stable with no dma_src_en during the stall.
  - Data order preserved; dma_cbe=4'b0010 appears as txs_byteenable=4'b1101.
- Read, cnt=8, addr=0x1000, read_valid gaps:
  - Burst_count=8, read held until waitrequest low.
  - 8 dma_data_vld with matching data, then dma_complete.
- cnt=0 and cnt=MAX_BURST+1: no txs activity; dma_complete and dma_error high 1 cycle after dma_request.
- Read with only 5 of 8 beats returned, TIMEOUT_CYCLES=16:
  - dma_lat_timeout and dma_error 16 cycles after the 5th beat; return to IDLE.
  - Late read_valid ignored.
- Reset asserted during WR beat 2: outputs zero the same cycle; a fresh write completes normally after reset.
